// File: rtl/pac_move_ctrl_if.sv
// rtl/pac_move_ctrl_if.sv - game-side signal bundle for the Pac-Man movement controller
//
// Purpose: groups the tick/joystick inputs and the sprite/game-state outputs of
// pac_move_ctrl so the game FSM, renderer and controller share one connection.
//
// Parameters:
//   POS_W  pixel coordinate width
//   COL_W  cell column index width ($clog2(GRID_COLS) of the controller)
//   ROW_W  cell row index width    ($clog2(GRID_ROWS) of the controller)
//
// Signals (direction seen from the controller, modport slave):
//   tick        in   one-cycle game-step strobe
//   freeze      in   1 = ignore ticks
//   btn_l/r/u/d in   joystick levels
//   xpos, ypos  out  sprite top-left pixel position
//   cell_col    out  current column
//   cell_row    out  current row
//   dir         out  last committed direction, 0=L 1=R 2=U 3=D
//   moving      out  sprite advanced on the last tick
//   aligned     out  sprite exactly on a cell
//   legal       out  {L,R,U,D} map nibble of the current cell
//
// Modports: master = game side (drives tick/freeze/buttons), slave = controller.

interface pac_move_ctrl_if #(
    parameter int POS_W = 10,
    parameter int COL_W = 3,
    parameter int ROW_W = 3
);
    logic             tick;
    logic             freeze;
    logic             btn_l;
    logic             btn_r;
    logic             btn_u;
    logic             btn_d;
    logic [POS_W-1:0] xpos;
    logic [POS_W-1:0] ypos;
    logic [COL_W-1:0] cell_col;
    logic [ROW_W-1:0] cell_row;
    logic [1:0]       dir;
    logic             moving;
    logic             aligned;
    logic [3:0]       legal;

    modport master (
        output tick, freeze, btn_l, btn_r, btn_u, btn_d,
        input  xpos, ypos, cell_col, cell_row, dir, moving, aligned, legal
    );

    modport slave (
        input  tick, freeze, btn_l, btn_r, btn_u, btn_d,
        output xpos, ypos, cell_col, cell_row, dir, moving, aligned, legal
    );
endinterface

// File: rtl/pac_move_ctrl.sv
// rtl/pac_move_ctrl.sv - Pac-Man sprite movement controller (cell + offset, legal-map gated)
//
// Purpose: holds the sprite's maze cell and in-cell offset, buffers joystick
// requests and advances the sprite STEP_PX pixels per game tick along corridors
// allowed by a per-cell {L,R,U,D} legality map.
//
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous reset, active low
//   bus    pac_move_ctrl_if.slave: tick, freeze, btn_l/r/u/d in;
//          xpos, ypos, cell_col, cell_row, dir, moving, aligned, legal out
//
// Configuration macro: TUNNEL_WRAP_EN
//   defined   - map-legal exits at the maze edge wrap to the opposite side
//   undefined - exits at the maze edge are always illegal, no wrap logic

module pac_move_ctrl #(
    parameter int GRID_COLS = 8,
    parameter int GRID_ROWS = 8,
    parameter int CELL_PX   = 60,
    parameter int ORIGIN_X  = 150,
    parameter int ORIGIN_Y  = 34,
    parameter int STEP_PX   = 1,
    parameter int POS_W     = 10,
    parameter int START_COL = 1,
    parameter int START_ROW = 1,
    parameter logic [4*GRID_ROWS*GRID_COLS-1:0] LEGAL_MAP =
        256'h01111000_45CC9800_43B73910_47CCEC98_43A22638_43911538_46CCCCA8_02222220
) (
    input  logic           clk,
    input  logic           rst_n,
    pac_move_ctrl_if.slave bus
);

    localparam int COL_W = $clog2(GRID_COLS);
    localparam int ROW_W = $clog2(GRID_ROWS);
    localparam int NCELL = GRID_COLS * GRID_ROWS;
    localparam int MAP_W = 4 * NCELL;
    localparam int IDX_W = $clog2(MAP_W);
    // One extra count so the R/D step can momentarily reach CELL_PX before rolling over.
    localparam int OFF_W = $clog2(CELL_PX + 1);

    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(GRID_COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(GRID_ROWS - 1);
    localparam logic [COL_W-1:0] RST_COL   = COL_W'(START_COL);
    localparam logic [ROW_W-1:0] RST_ROW   = ROW_W'(START_ROW);
    localparam logic [OFF_W-1:0] STEP      = OFF_W'(STEP_PX);
    localparam logic [OFF_W-1:0] OFF_MAX   = OFF_W'(CELL_PX - STEP_PX);
    localparam logic [OFF_W-1:0] OFF_FULL  = OFF_W'(CELL_PX);
    localparam logic [POS_W-1:0] RST_X     = POS_W'(ORIGIN_X + START_COL * CELL_PX);
    localparam logic [POS_W-1:0] RST_Y     = POS_W'(ORIGIN_Y + START_ROW * CELL_PX);

    localparam logic [1:0] DIR_L = 2'd0;
    localparam logic [1:0] DIR_R = 2'd1;
    localparam logic [1:0] DIR_U = 2'd2;
    localparam logic [1:0] DIR_D = 2'd3;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_MOVE = 1'b1
    } state_t;

    state_t           state_q,  state_d;
    logic [1:0]       dir_q,    dir_d;
    logic [COL_W-1:0] col_q,    col_d;
    logic [ROW_W-1:0] row_q,    row_d;
    logic [OFF_W-1:0] off_q,    off_d;
    logic             moving_q, moving_d;
    logic             req_vld_q, req_vld_d;
    logic [1:0]       req_dir_q, req_dir_d;
    logic [POS_W-1:0] xpos_q,   xpos_d;
    logic [POS_W-1:0] ypos_q,   ypos_d;

    logic             req_vld_eff;
    logic [1:0]       req_dir_eff;
    logic [3:0]       cell_legal;
    logic [3:0]       eff_legal;
    logic             aligned;
    logic             step_en;
    logic             take_step;
    logic [1:0]       step_dir;
    logic [OFF_W-1:0] off_sum;

    // Cell k = row*GRID_COLS + col is nibble k counted from the MSB of the map.
    function automatic logic [3:0] map_nibble(input logic [COL_W-1:0] c,
                                              input logic [ROW_W-1:0] r);
        int               k;
        logic [IDX_W-1:0] idx;
        k   = int'(r) * GRID_COLS + int'(c);
        idx = IDX_W'(4 * (NCELL - 1 - k));
        return LEGAL_MAP[idx +: 4];
    endfunction

    function automatic logic [COL_W-1:0] col_inc(input logic [COL_W-1:0] c);
`ifdef TUNNEL_WRAP_EN
        return (c == LAST_COL) ? '0 : c + 1'b1;
`else
        return c + 1'b1;
`endif
    endfunction

    function automatic logic [COL_W-1:0] col_dec(input logic [COL_W-1:0] c);
`ifdef TUNNEL_WRAP_EN
        return (c == '0) ? LAST_COL : c - 1'b1;
`else
        return c - 1'b1;
`endif
    endfunction

    function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r);
`ifdef TUNNEL_WRAP_EN
        return (r == LAST_ROW) ? '0 : r + 1'b1;
`else
        return r + 1'b1;
`endif
    endfunction

    function automatic logic [ROW_W-1:0] row_dec(input logic [ROW_W-1:0] r);
`ifdef TUNNEL_WRAP_EN
        return (r == '0) ? LAST_ROW : r - 1'b1;
`else
        return r - 1'b1;
`endif
    endfunction

    assign cell_legal = map_nibble(col_q, row_q);
    assign aligned    = (off_q == '0);
    assign step_en    = bus.tick & ~bus.freeze;
    assign off_sum    = off_q + STEP;

`ifdef TUNNEL_WRAP_EN
    assign eff_legal = cell_legal;
`else
    // Edge exits are closed whatever the map says.
    assign eff_legal = {cell_legal[3] & (col_q != '0),
                        cell_legal[2] & (col_q != LAST_COL),
                        cell_legal[1] & (row_q != '0),
                        cell_legal[0] & (row_q != LAST_ROW)};
`endif

    // A button held this cycle overrides the buffered request so that a press
    // coinciding with a tick is acted on by that tick.
    always_comb begin
        req_vld_eff = req_vld_q;
        req_dir_eff = req_dir_q;
        if (bus.btn_l) begin
            req_vld_eff = 1'b1;
            req_dir_eff = DIR_L;
        end else if (bus.btn_r) begin
            req_vld_eff = 1'b1;
            req_dir_eff = DIR_R;
        end else if (bus.btn_u) begin
            req_vld_eff = 1'b1;
            req_dir_eff = DIR_U;
        end else if (bus.btn_d) begin
            req_vld_eff = 1'b1;
            req_dir_eff = DIR_D;
        end
    end

    // Next-state: movement decision then the single-axis step.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        col_d     = col_q;
        row_d     = row_q;
        off_d     = off_q;
        moving_d  = moving_q;
        req_vld_d = req_vld_eff;
        req_dir_d = req_dir_eff;
        take_step = 1'b0;
        step_dir  = dir_q;

        if (bus.freeze) begin
            moving_d = 1'b0;
        end

        if (step_en) begin
            if (aligned) begin
                if (req_vld_eff && eff_legal[2'd3 - req_dir_eff]) begin
                    dir_d     = req_dir_eff;
                    step_dir  = req_dir_eff;
                    req_vld_d = 1'b0;
                    state_d   = ST_MOVE;
                    take_step = 1'b1;
                end else if (state_q == ST_MOVE && eff_legal[2'd3 - dir_q]) begin
                    take_step = 1'b1;
                end else begin
                    state_d = ST_STOP;
                end
            end else begin
                // Between cells the sprite always moves; only a reversal may
                // be applied here, other requests wait for the next cell.
                state_d   = ST_MOVE;
                take_step = 1'b1;
                if (req_vld_eff && req_dir_eff == (dir_q ^ 2'b01)) begin
                    dir_d     = req_dir_eff;
                    step_dir  = req_dir_eff;
                    req_vld_d = 1'b0;
                end
            end
            moving_d = take_step;

            // The offset always measures from the lower-indexed cell, so L/U
            // steps out of an aligned cell move the cell index first.
            if (take_step) begin
                case (step_dir)
                    DIR_R: begin
                        if (off_sum == OFF_FULL) begin
                            off_d = '0;
                            col_d = col_inc(col_q);
                        end else begin
                            off_d = off_sum;
                        end
                    end
                    DIR_D: begin
                        if (off_sum == OFF_FULL) begin
                            off_d = '0;
                            row_d = row_inc(row_q);
                        end else begin
                            off_d = off_sum;
                        end
                    end
                    DIR_L: begin
                        if (aligned) begin
                            col_d = col_dec(col_q);
                            off_d = OFF_MAX;
                        end else begin
                            off_d = off_q - STEP;
                        end
                    end
                    default: begin
                        if (aligned) begin
                            row_d = row_dec(row_q);
                            off_d = OFF_MAX;
                        end else begin
                            off_d = off_q - STEP;
                        end
                    end
                endcase
            end
        end
    end

    // Pixel position follows the next cell/offset so it lands with the step.
    always_comb begin
        xpos_d = POS_W'(ORIGIN_X) + POS_W'(col_d) * POS_W'(CELL_PX);
        ypos_d = POS_W'(ORIGIN_Y) + POS_W'(row_d) * POS_W'(CELL_PX);
        if (dir_d[1] == 1'b0) begin
            xpos_d = xpos_d + POS_W'(off_d);
        end else begin
            ypos_d = ypos_d + POS_W'(off_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_STOP;
            dir_q     <= DIR_L;
            col_q     <= RST_COL;
            row_q     <= RST_ROW;
            off_q     <= '0;
            moving_q  <= 1'b0;
            req_vld_q <= 1'b0;
            req_dir_q <= DIR_L;
            xpos_q    <= RST_X;
            ypos_q    <= RST_Y;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            col_q     <= col_d;
            row_q     <= row_d;
            off_q     <= off_d;
            moving_q  <= moving_d;
            req_vld_q <= req_vld_d;
            req_dir_q <= req_dir_d;
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
        end
    end

    assign bus.xpos     = xpos_q;
    assign bus.ypos     = ypos_q;
    assign bus.cell_col = col_q;
    assign bus.cell_row = row_q;
    assign bus.dir      = dir_q;
    assign bus.moving   = moving_q;
    assign bus.aligned  = aligned;
    assign bus.legal    = cell_legal;

endmodule

// File: tb/tb_pac_move_ctrl.sv
// tb/tb_pac_move_ctrl.sv - scoreboard bench for pac_move_ctrl
module tb_pac_move_ctrl;

    localparam logic [255:0] MAP2 =
        256'h01111000_45CC9800_43B73910_C7CCEC98_43A22638_43911538_46CCCCA8_02222220;

    localparam int S_X    = 0;
    localparam int S_Y    = 1;
    localparam int S_COL  = 2;
    localparam int S_ROW  = 3;
    localparam int S_DIR  = 4;
    localparam int S_MOV  = 5;
    localparam int S_ALN  = 6;
    localparam int S_LEG  = 7;
    localparam int S2_X   = 8;
    localparam int S2_COL = 9;
    localparam int S2_MOV = 10;
    localparam int S2_DIR = 11;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    typedef struct {
        string tag;
        int    sel;
        int    val;
    } exp_t;

    exp_t sb[$];

    pac_move_ctrl_if #(.POS_W(10), .COL_W(3), .ROW_W(3)) bus ();
    pac_move_ctrl_if #(.POS_W(10), .COL_W(3), .ROW_W(3)) bus2 ();

    pac_move_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pac_move_ctrl #(
        .START_COL (0),
        .START_ROW (3),
        .LEGAL_MAP (MAP2)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_X:     return 32'(bus.xpos);
            S_Y:     return 32'(bus.ypos);
            S_COL:   return 32'(bus.cell_col);
            S_ROW:   return 32'(bus.cell_row);
            S_DIR:   return 32'(bus.dir);
            S_MOV:   return 32'(bus.moving);
            S_ALN:   return 32'(bus.aligned);
            S_LEG:   return 32'(bus.legal);
            S2_X:    return 32'(bus2.xpos);
            S2_COL:  return 32'(bus2.cell_col);
            S2_MOV:  return 32'(bus2.moving);
            default: return 32'(bus2.dir);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.sel), 32'(e.val));
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: bus.btn_l = v;
            1: bus.btn_r = v;
            2: bus.btn_u = v;
            3: bus.btn_d = v;
            default: ;
        endcase
    endtask

    // One tick, optionally with a button pressed in the same cycle; returns
    // at the following falling edge with outputs settled.
    task automatic step_btn(input int b);
        @(negedge clk);
        bus.tick = 1'b1;
        set_btn(b, 1'b1);
        @(negedge clk);
        bus.tick = 1'b0;
        set_btn(b, 1'b0);
    endtask

    task automatic step(input int n);
        repeat (n) step_btn(-1);
    endtask

    task automatic press(input int b);
        @(negedge clk);
        set_btn(b, 1'b1);
        @(negedge clk);
        set_btn(b, 1'b0);
    endtask

    task automatic expect_reset(input string tag);
        expect_val({tag, "_x"},   S_X,   210);
        expect_val({tag, "_y"},   S_Y,   94);
        expect_val({tag, "_col"}, S_COL, 1);
        expect_val({tag, "_row"}, S_ROW, 1);
        expect_val({tag, "_leg"}, S_LEG, 5);
        expect_val({tag, "_mov"}, S_MOV, 0);
        expect_val({tag, "_aln"}, S_ALN, 1);
        expect_val({tag, "_dir"}, S_DIR, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.tick = 0; bus.freeze = 0;
        bus.btn_l = 0; bus.btn_r = 0; bus.btn_u = 0; bus.btn_d = 0;
        bus2.tick = 0; bus2.freeze = 0;
        bus2.btn_l = 0; bus2.btn_r = 0; bus2.btn_u = 0; bus2.btn_d = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        expect_reset("rst");
        drain();

        // Right press, one pixel per tick, crossing into col 2 on tick 60
        press(1);
        for (int k = 1; k <= 60; k++) begin
            expect_val("r_x", S_X, 210 + k);
            step(1);
            drain();
        end
        expect_val("r60_col", S_COL, 2);
        expect_val("r60_aln", S_ALN, 1);
        expect_val("r60_dir", S_DIR, 1);
        expect_val("r60_mov", S_MOV, 1);
        drain();
        step(1);
        expect_val("r61_x", S_X, 271);
        drain();
        // Keeps going to col 4 where R is closed, then stops
        step(119);
        expect_val("r_c4_x",   S_X,   390);
        expect_val("r_c4_col", S_COL, 4);
        expect_val("r_c4_aln", S_ALN, 1);
        expect_val("r_c4_leg", S_LEG, 9);
        drain();
        step(1);
        expect_val("stop_x",   S_X,   390);
        expect_val("stop_mov", S_MOV, 0);
        expect_val("stop_dir", S_DIR, 1);
        drain();

        // Illegal request held; then an overriding legal press
        do_reset();
        @(negedge clk);
        bus.btn_l = 1'b1;
        for (int k = 0; k < 5; k++) begin
            expect_val("ill_x",   S_X,   210);
            expect_val("ill_mov", S_MOV, 0);
            step(1);
            drain();
        end
        bus.btn_l = 1'b0;
        press(3);
        step(1);
        expect_val("d_y",   S_Y,   95);
        expect_val("d_x",   S_X,   210);
        expect_val("d_dir", S_DIR, 3);
        expect_val("d_mov", S_MOV, 1);
        expect_val("d_aln", S_ALN, 0);
        drain();

        // Mid-cell reversal, button pressed in the tick cycle itself
        do_reset();
        press(1);
        step(10);
        expect_val("rev_pre_x", S_X, 220);
        drain();
        step_btn(0);
        expect_val("rev_x",   S_X,   219);
        expect_val("rev_dir", S_DIR, 0);
        expect_val("rev_mov", S_MOV, 1);
        drain();
        step(9);
        expect_val("rev_end_x",   S_X,   210);
        expect_val("rev_end_col", S_COL, 1);
        expect_val("rev_end_aln", S_ALN, 1);
        drain();

        // Freeze mid-move, request latched while frozen, async reset mid-move
        do_reset();
        press(1);
        step(5);
        @(negedge clk);
        bus.freeze = 1'b1;
        for (int k = 0; k < 20; k++) begin
            expect_val("frz_x",   S_X,   215);
            expect_val("frz_mov", S_MOV, 0);
            step(1);
            drain();
        end
        press(0);
        @(negedge clk);
        bus.freeze = 1'b0;
        step(1);
        expect_val("thaw_x",   S_X,   214);
        expect_val("thaw_dir", S_DIR, 0);
        expect_val("thaw_mov", S_MOV, 1);
        drain();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_reset("arst");
        drain();
        @(negedge clk);
        rst_n = 1'b1;

        // Edge exit on the second instance: cell (row 3, col 0) opens L and R
        do_reset();
        expect_val("edge_rst_col", S2_COL, 0);
        expect_val("edge_rst_x",   S2_X,   150);
        drain();
        @(negedge clk);
        bus2.tick  = 1'b1;
        bus2.btn_l = 1'b1;
        @(negedge clk);
        bus2.tick  = 1'b0;
        bus2.btn_l = 1'b0;
`ifdef TUNNEL_WRAP_EN
        expect_val("wrap_col", S2_COL, 7);
        expect_val("wrap_mov", S2_MOV, 1);
        expect_val("wrap_dir", S2_DIR, 0);
`else
        expect_val("edge_col", S2_COL, 0);
        expect_val("edge_x",   S2_X,   150);
        expect_val("edge_mov", S2_MOV, 0);
`endif
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
